// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the execute stage.
//   op_e        - 4-bit operation code driven by the issue stage.
//   div_state_e - iterative divider FSM states.
//   is_div_op() - true for the four divide/modulo operations.
package ex_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_DIV, OP_DIVU, OP_MOD, OP_MODU
  } op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_MOD) || (op == OP_MODU);
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// ex_div_iter: iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   start             - begin a divide (honoured only in IDLE)
//   signed_op         - operands are two's complement
//   want_rem          - result is the remainder instead of the quotient
//   a, b              - dividend, divisor (sampled on the start edge)
//   kill              - abandon any divide and return to IDLE
//   busy, done        - FSM is in BUSY / DONE
//   ack               - result consumed; DONE -> IDLE
//   result            - fixed-up quotient or remainder, valid in DONE
module ex_div_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_op,
  input  logic            want_rem,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  input  logic            ack,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  div_state_e      r_state;
  logic [XLEN-1:0] r_quo;      // shifts the dividend out, quotient bits in
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;
  logic [CW-1:0]   r_count;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_dz;
  logic            r_want_rem;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic            w_fit;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  assign w_a_neg = signed_op & a[XLEN-1];
  assign w_b_neg = signed_op & b[XLEN-1];
  // Negating MIN yields MIN, which is the correct unsigned magnitude.
  assign w_abs_a = w_a_neg ? -a : a;
  assign w_abs_b = w_b_neg ? -b : b;

  // Partial remainder stays below the divisor, so XLEN+1 bits hold the trial
  // subtraction and its MSB is the borrow.
  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  assign w_fit    = ~w_diff[XLEN];

  // Divide by zero naturally leaves rem = |a|, which fixes up to a; only the
  // quotient needs forcing so the sign fix-up cannot turn all-ones into 1.
  assign w_q_fix = r_dz ? '1 : (r_neg_q ? -r_quo : r_quo);
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;
  assign result  = r_want_rem ? w_r_fix : w_q_fix;

  assign busy = (r_state == BUSY);
  assign done = (r_state == DONE);

  // NOTE: every register, including the datapath, is reset so all outputs
  // are defined immediately after reset; sequential state uses non-blocking
  // assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_quo      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_count    <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_want_rem <= 1'b0;
    end else if (kill) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state    <= BUSY;
          r_quo      <= w_abs_a;
          r_div      <= w_abs_b;
          r_rem      <= '0;
          r_count    <= CW'(XLEN);
          r_neg_q    <= w_a_neg ^ w_b_neg;
          r_neg_r    <= w_a_neg;
          r_dz       <= (b == '0);
          r_want_rem <= want_rem;
        end
        BUSY: begin
          r_rem   <= w_fit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
          r_quo   <= {r_quo[XLEN-2:0], w_fit};
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) r_state <= DONE;
        end
        DONE: if (ack) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_param.sv
// ex_stage_param: execute stage between issue (IS) and memory (MS).
// Latches one instruction per handshake, evaluates integer ops inline and
// runs divide/modulo on ex_div_iter when EX_DIV_EN is defined. Without
// EX_DIV_EN divide ops complete immediately with a zero result.
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   es_stall, es_flush            - hazard hold, stage kill
//   ms_allowin / es_allowin       - downstream / upstream handshake
//   is_*                          - instruction payload from IS
//   es_to_ms_valid, es_*          - result and registered payload to MS
//   fwd_*                         - forwarding port back to IS
//   hz_div_busy, hz_has_ld        - hazard indications
//   data_sram_addr                - data SRAM address (the ALU result)
module ex_stage_param
  import ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            es_stall,
  input  logic            es_flush,
  input  logic            ms_allowin,
  output logic            es_allowin,
  input  logic            is_to_es_valid,
  input  op_e             is_op,
  input  logic [XLEN-1:0] is_src1,
  input  logic [XLEN-1:0] is_src2,
  input  logic            is_gr_we,
  input  logic            is_mem_we,
  input  logic            is_res_from_mem,
  input  logic [RA_W-1:0] is_dest,
  input  logic [XLEN-1:0] is_st_data,
  input  logic [XLEN-1:0] is_pc,
  output logic            es_to_ms_valid,
  output logic [XLEN-1:0] es_result,
  output logic            es_gr_we,
  output logic            es_mem_we,
  output logic            es_res_from_mem,
  output logic [RA_W-1:0] es_dest,
  output logic [XLEN-1:0] es_st_data,
  output logic [XLEN-1:0] es_pc,
  output logic            fwd_en,
  output logic            fwd_ok,
  output logic [RA_W-1:0] fwd_dest,
  output logic [XLEN-1:0] fwd_data,
  output logic            hz_div_busy,
  output logic            hz_has_ld,
  output logic [XLEN-1:0] data_sram_addr
);

  localparam int SHW = $clog2(XLEN);

  logic            r_es_valid;
  op_e             r_op;
  logic [XLEN-1:0] r_src1;
  logic [XLEN-1:0] r_src2;
  logic            r_gr_we;
  logic            r_mem_we;
  logic            r_res_from_mem;
  logic [RA_W-1:0] r_dest;
  logic [XLEN-1:0] r_st_data;
  logic [XLEN-1:0] r_pc;

  logic            w_ready_go;
  logic            w_is_div;
  logic [XLEN-1:0] w_alu;
  logic [SHW-1:0]  w_sh;

  assign w_is_div = is_div_op(r_op);
  assign w_sh     = r_src2[SHW-1:0];

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_src1 + r_src2;
      OP_SUB:  w_alu = r_src1 - r_src2;
      OP_AND:  w_alu = r_src1 & r_src2;
      OP_OR:   w_alu = r_src1 | r_src2;
      OP_XOR:  w_alu = r_src1 ^ r_src2;
      OP_NOR:  w_alu = ~(r_src1 | r_src2);
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(r_src1) < $signed(r_src2)};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, r_src1 < r_src2};
      OP_SLL:  w_alu = r_src1 << w_sh;
      OP_SRL:  w_alu = r_src1 >> w_sh;
      OP_SRA:  w_alu = $unsigned($signed(r_src1) >>> w_sh);
      OP_LUI:  w_alu = r_src2;
      default: w_alu = '0;
    endcase
  end

`ifdef EX_DIV_EN
  logic            w_div_busy;
  logic            w_div_done;
  logic [XLEN-1:0] w_div_result;

  // start is only honoured in IDLE, so a held divide does not restart and a
  // divide captured on the ack edge starts on the very next cycle.
  ex_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (r_es_valid & w_is_div),
    .signed_op ((r_op == OP_DIV) | (r_op == OP_MOD)),
    .want_rem  ((r_op == OP_MOD) | (r_op == OP_MODU)),
    .a         (r_src1),
    .b         (r_src2),
    .kill      (es_flush),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .ack       (es_to_ms_valid & ms_allowin),
    .result    (w_div_result)
  );

  assign w_ready_go  = ~w_is_div | w_div_done;
  assign es_result   = w_is_div ? w_div_result : w_alu;
  assign hz_div_busy = w_div_busy;
`else
  assign w_ready_go  = 1'b1;
  assign es_result   = w_is_div ? '0 : w_alu;
  assign hz_div_busy = 1'b0;
`endif

  assign es_allowin     = (~r_es_valid | (w_ready_go & ms_allowin)) & ~es_stall;
  assign es_to_ms_valid = r_es_valid & w_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_es_valid     <= 1'b0;
      r_op           <= OP_ADD;
      r_src1         <= '0;
      r_src2         <= '0;
      r_gr_we        <= 1'b0;
      r_mem_we       <= 1'b0;
      r_res_from_mem <= 1'b0;
      r_dest         <= '0;
      r_st_data      <= '0;
      r_pc           <= '0;
    end else begin
      // Flush wins over a concurrent capture.
      if (es_flush)        r_es_valid <= 1'b0;
      else if (es_allowin) r_es_valid <= is_to_es_valid;
      if (is_to_es_valid & es_allowin & ~es_flush) begin
        r_op           <= is_op;
        r_src1         <= is_src1;
        r_src2         <= is_src2;
        r_gr_we        <= is_gr_we;
        r_mem_we       <= is_mem_we;
        r_res_from_mem <= is_res_from_mem;
        r_dest         <= is_dest;
        r_st_data      <= is_st_data;
        r_pc           <= is_pc;
      end
    end
  end

  assign es_gr_we        = r_gr_we;
  assign es_mem_we       = r_mem_we;
  assign es_res_from_mem = r_res_from_mem;
  assign es_dest         = r_dest;
  assign es_st_data      = r_st_data;
  assign es_pc           = r_pc;

  assign fwd_en         = r_es_valid & r_gr_we & (r_dest != '0);
  assign fwd_ok         = fwd_en & w_ready_go;
  assign fwd_dest       = r_dest;
  assign fwd_data       = es_result;
  assign hz_has_ld      = r_es_valid & r_res_from_mem;
  assign data_sram_addr = es_result;

endmodule

// File: tb/tb_ex_stage_param.sv
// tb_ex_stage_param: self-checking bench for ex_stage_param (XLEN=32).
// Expected results come from plain SystemVerilog integer arithmetic; the
// divide expectations follow whether EX_DIV_EN is defined for the build.
module tb_ex_stage_param;
  import ex_pkg::*;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic            es_stall, es_flush, ms_allowin, es_allowin;
  logic            is_to_es_valid;
  op_e             is_op;
  logic [XLEN-1:0] is_src1, is_src2, is_st_data, is_pc;
  logic            is_gr_we, is_mem_we, is_res_from_mem;
  logic [RA_W-1:0] is_dest;
  logic            es_to_ms_valid;
  logic [XLEN-1:0] es_result, es_st_data, es_pc, fwd_data, data_sram_addr;
  logic            es_gr_we, es_mem_we, es_res_from_mem;
  logic [RA_W-1:0] es_dest, fwd_dest;
  logic            fwd_en, fwd_ok, hz_div_busy, hz_has_ld;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage_param #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset), .es_stall(es_stall), .es_flush(es_flush),
    .ms_allowin(ms_allowin), .es_allowin(es_allowin),
    .is_to_es_valid(is_to_es_valid), .is_op(is_op),
    .is_src1(is_src1), .is_src2(is_src2), .is_gr_we(is_gr_we),
    .is_mem_we(is_mem_we), .is_res_from_mem(is_res_from_mem),
    .is_dest(is_dest), .is_st_data(is_st_data), .is_pc(is_pc),
    .es_to_ms_valid(es_to_ms_valid), .es_result(es_result),
    .es_gr_we(es_gr_we), .es_mem_we(es_mem_we),
    .es_res_from_mem(es_res_from_mem), .es_dest(es_dest),
    .es_st_data(es_st_data), .es_pc(es_pc), .fwd_en(fwd_en),
    .fwd_ok(fwd_ok), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .hz_div_busy(hz_div_busy), .hz_has_ld(hz_has_ld),
    .data_sram_addr(data_sram_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_MOD, OP_MODU};
  endfunction

  // Reference: the arithmetic meaning of each op.
  function automatic logic [31:0] ref_result(input op_e op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == MIN) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a << (b % 32);
      OP_SRL:  return a >> (b % 32);
      OP_SRA:  return sa >>> (b % 32);
      OP_LUI:  return b;
      OP_DIV:  return !DIV_EN ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN : sa / sb;
      OP_DIVU: return !DIV_EN ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_MOD:  return !DIV_EN ? 32'd0 : (b == 0) ? a : ovf ? 32'd0 : sa % sb;
      OP_MODU: return !DIV_EN ? 32'd0 : (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input op_e op);
    return (DIV_EN && is_div(op)) ? XLEN + 1 : 0;
  endfunction

  task automatic set_is(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input logic gr);
    is_op = op; is_src1 = a; is_src2 = b; is_dest = dest; is_gr_we = gr;
    is_mem_we = 1'b0; is_res_from_mem = 1'b0;
    is_st_data = $urandom; is_pc = $urandom;
  endtask

  // Issue one instruction, measure its latency, hold it in MS-stall for
  // `hold` cycles, then let MS take it and confirm the stage drains.
  task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input logic gr, input int hold,
                        input string tag);
    logic [31:0] exp, pc;
    int k, nbusy, bad;
    exp = ref_result(op, a, b);
    @(negedge clk);
    set_is(op, a, b, dest, gr);
    pc = is_pc;
    is_to_es_valid = 1'b1;
    ms_allowin     = 1'b0;
    k = 0;
    while (!es_allowin && k < 50) begin @(negedge clk); k++; end
    if (k == 50) check({tag, "_accept_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
    is_to_es_valid = 1'b0;
    k = 0; nbusy = 0;
    while (!es_to_ms_valid && k < 100) begin
      nbusy += int'(hz_div_busy);
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, k, exp_lat(op));
    check({tag, "_busy_cycles"}, nbusy, (DIV_EN && is_div(op)) ? XLEN : 0);
    check({tag, "_result"}, es_result, exp);
    check({tag, "_fwd_ok"}, fwd_ok, gr && dest != 0);
    check({tag, "_pc"}, es_pc, pc);
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (es_result !== exp || !es_to_ms_valid || es_allowin) bad++;
    end
    if (hold > 0) check({tag, "_hold"}, bad, 0);
    ms_allowin = 1'b1;
    @(negedge clk);
    ms_allowin = 1'b0;
    check({tag, "_drained"}, {es_to_ms_valid, hz_div_busy}, 2'b00);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return MIN;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] m7;
    int k;
    m7 = -32'sd7;
    reset = 1'b1; es_stall = 1'b0; es_flush = 1'b0; ms_allowin = 1'b0;
    is_to_es_valid = 1'b0;
    set_is(OP_ADD, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_valid", es_to_ms_valid, 1'b0);
    check("rst_result", es_result, 32'd0);
    check("rst_busy", hz_div_busy, 1'b0);
    check("rst_fwd_en", {fwd_en, hz_has_ld}, 2'b00);
    check("rst_pc", es_pc, 32'd0);
    reset = 1'b0;

    // Directed cases from the test plan.
    run_op(OP_ADD,  32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1, 0, "add_ovf");
    run_op(OP_DIV,  m7, 32'd2, 5'd4, 1'b1, 0, "div_m7_2");
    run_op(OP_MOD,  m7, 32'd2, 5'd4, 1'b1, 5, "mod_m7_2_hold");
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd1, 1'b1, 0, "divu_by0");
    run_op(OP_MODU, 32'd5, 32'd0, 5'd1, 1'b1, 0, "modu_by0");
    run_op(OP_DIV,  MIN, 32'hFFFF_FFFF, 5'd2, 1'b1, 0, "div_min_m1");
    run_op(OP_MOD,  MIN, 32'hFFFF_FFFF, 5'd2, 1'b1, 0, "mod_min_m1");
    run_op(OP_DIV,  32'd9, 32'd3, 5'd0, 1'b1, 0, "div_9_3");
    run_op(OP_SRA,  MIN, 32'd35, 5'd7, 1'b1, 0, "sra_wrap");
    run_op(OP_SLT,  32'hFFFF_FFFF, 32'd1, 5'd7, 1'b0, 0, "slt_neg");

    // Flush in the middle of a divide, then an ADD must not see it.
    @(negedge clk);
    set_is(OP_DIV, m7, 32'd2, 5'd5, 1'b1);
    is_to_es_valid = 1'b1;
    @(negedge clk);
    is_to_es_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_pre_busy", hz_div_busy, DIV_EN);
    es_flush = 1'b1;
    @(negedge clk);
    es_flush = 1'b0;
    check("flush_post", {es_to_ms_valid, hz_div_busy, fwd_en}, 3'b000);
    run_op(OP_ADD, 32'd3, 32'd4, 5'd6, 1'b1, 0, "add_after_flush");

    // Stall blocks capture.
    @(negedge clk);
    set_is(OP_ADD, 32'd1, 32'd1, 5'd1, 1'b1);
    es_stall = 1'b1; is_to_es_valid = 1'b1;
    @(negedge clk);
    check("stall_block", {es_allowin, es_to_ms_valid}, 2'b00);
    is_to_es_valid = 1'b0; es_stall = 1'b0;

    // Back-to-back divides: second one captured on the first's ack edge.
    @(negedge clk);
    set_is(OP_DIV, 32'd100, 32'd7, 5'd8, 1'b1);
    is_to_es_valid = 1'b1; ms_allowin = 1'b1;
    @(negedge clk);
    set_is(OP_DIVU, 32'd1000, 32'd3, 5'd9, 1'b1);
    k = 0;
    while (!es_to_ms_valid && k < 100) begin @(negedge clk); k++; end
    check("b2b_a_lat", k, exp_lat(OP_DIV));
    check("b2b_a_res", es_result, ref_result(OP_DIV, 32'd100, 32'd7));
    @(negedge clk);
    is_to_es_valid = 1'b0;
    k = 0;
    while (!es_to_ms_valid && k < 100) begin @(negedge clk); k++; end
    check("b2b_b_lat", k, exp_lat(OP_DIVU));
    check("b2b_b_res", es_result, ref_result(OP_DIVU, 32'd1000, 32'd3));
    @(negedge clk);
    ms_allowin = 1'b0;
    check("b2b_drained", es_to_ms_valid, 1'b0);

    // Reset asserted mid-divide drops busy without waiting for a clock.
    @(negedge clk);
    set_is(OP_DIVU, 32'd77, 32'd5, 5'd3, 1'b1);
    is_to_es_valid = 1'b1;
    @(negedge clk);
    is_to_es_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rstdiv_pre_busy", hz_div_busy, DIV_EN);
    reset = 1'b1;
    #1;
    check("rstdiv_async", {hz_div_busy, es_to_ms_valid}, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    // Randomised mix.
    for (int i = 0; i < 40; i++) begin
      run_op(op_e'($urandom_range(0, 15)), pick(), pick(), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
